// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared divider state encodings, ready flags and EX ALU op codes.
package div_sequencer_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BYZERO, DIV_BUSY, DIV_DONE} div_state_t;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [7:0] EXE_DIV_OP = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration (shift in a dividend bit, trial subtract).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_next,
  output logic             q
);
  logic [WIDTH:0] wide;
  assign wide = {rem, bit_in};
  assign q = wide >= {1'b0, divisor};
  assign rem_next = q ? WIDTH'(wide - {1'b0, divisor}) : WIDTH'(wide);
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider with control FSM, returns {remainder, quotient}.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   oprand1_i,
  input  logic [WIDTH-1:0]   oprand2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);
  localparam int CW = $clog2(WIDTH);
  div_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dsr, rem, rem_n, mag1, mag2, quot_raw, quot, remd;
  logic q, neg_q, neg_r, accept, last;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .divisor(dsr),
    .bit_in(dvd[WIDTH-1]),
    .rem_next(rem_n),
    .q(q)
  );
  assign mag1 = (signed_i & oprand1_i[WIDTH-1]) ? -oprand1_i : oprand1_i;
  assign mag2 = (signed_i & oprand2_i[WIDTH-1]) ? -oprand2_i : oprand2_i;
  assign accept = (state == DIV_IDLE) & start_i & ~annul_i;
  assign last = cnt == CW'(WIDTH - 1);
  // the dividend register doubles as the quotient shift register
  assign quot_raw = {dvd[WIDTH-2:0], q};
  assign quot = neg_q ? -quot_raw : quot_raw;
  assign remd = neg_r ? -rem_n : rem_n;
  assign ready_o = (state == DIV_DONE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign stall_o = start_i & ~ready_o & ~annul_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= DIV_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = DIV_IDLE;
    if (!annul_i)
      nxt = (state == DIV_IDLE)   ? (start_i ? ((oprand2_i == '0) ? DIV_BYZERO : DIV_BUSY) : DIV_IDLE) :
            (state == DIV_BYZERO) ? DIV_DONE :
            (state == DIV_BUSY)   ? (last ? DIV_DONE : DIV_BUSY) :
                                    (start_i ? DIV_DONE : DIV_IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result_o <= '0;
    end else begin
      if (accept) begin
        dvd <= mag1;
        dsr <= mag2;
        rem <= '0;
        cnt <= '0;
        neg_q <= signed_i & (oprand1_i[WIDTH-1] ^ oprand2_i[WIDTH-1]);
        neg_r <= signed_i & oprand1_i[WIDTH-1];
      end else if (state == DIV_BUSY) begin
        dvd <= quot_raw;
        rem <= rem_n;
        cnt <= cnt + 1'b1;
      end
      // result is nonzero only while in DONE; sign fix lands on the final iteration edge
      result_o <= (nxt != DIV_DONE) ? '0 : (state == DIV_BUSY) ? {remd, quot} : result_o;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized divides checked every cycle against an arithmetic/timing model.
module tb_div_sequencer;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0, sgn = 0, annul = 0;
  logic [W-1:0] a = 0, b = 0;
  logic [2*W-1:0] result;
  logic ready, stall;
  int checks = 0, failures = 0, cyc = 0;
  logic m_busy = 0, m_done = 0;
  int m_due = 0;
  logic [2*W-1:0] m_exp = 0;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
    .oprand1_i(a), .oprand2_i(b), .annul_i(annul),
    .result_o(result), .ready_o(ready), .stall_o(stall)
  );

  function automatic logic [63:0] ref_div(logic [31:0] x, logic [31:0] y, logic s);
    longint sx, sy, q, r;
    if (y == 0) return 64'd0;
    if (!s) return {x % y, x / y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: accept -> ready after WIDTH edges (1 edge for divide by zero)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0;
      m_done <= 0;
      m_exp <= 0;
    end else if (annul) begin
      m_busy <= 0;
      m_done <= 0;
    end else if (m_done) begin
      if (!start) m_done <= 0;
    end else if (m_busy) begin
      if (cyc + 1 == m_due) begin
        m_busy <= 0;
        m_done <= 1;
      end
    end else if (start) begin
      m_busy <= 1;
      m_due <= cyc + 1 + ((b == 0) ? 1 : W);
      m_exp <= ref_div(a, b, sgn);
    end
  end

  always @(negedge clk) begin
    check("ready", 64'(ready), 64'(m_done));
    check("stall", 64'(stall), 64'(start & ~m_done & ~annul));
    check("result", result, m_done ? m_exp : 64'd0);
  end

  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic s, input int hold,
                     output logic [63:0] res, output int lat);
    a = x; b = y; sgn = s; start = 1;
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin a = $urandom; b = $urandom; sgn = $urandom_range(0, 1); end
    end
    check("wait_ready", 64'(ready), 64'd1);
    res = result;
    repeat (hold) begin @(posedge clk); #1; end
    check("hold_stable", result, res);
    start = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int lat, ac, i;
    logic da;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_result", result, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("ref_divu", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    check("ref_div_neg", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("ref_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
    @(posedge clk); #1;
    run(32'd100, 32'd7, 1'b0, 0, res, lat);
    check("divu_lat", 64'(lat), 64'd33);
    check("divu_res", res, {32'd2, 32'd14});
    run(32'hFFFF_FFF9, 32'd2, 1'b1, 0, res, lat);
    check("div_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run(32'd7, 32'hFFFF_FFFE, 1'b1, 0, res, lat);
    check("div_7_m2", res, {32'd1, 32'hFFFF_FFFD});
    run(32'd5, 32'd0, 1'b0, 0, res, lat);
    check("zero_u_lat", 64'(lat), 64'd2);
    check("zero_u_res", res, 64'd0);
    run(32'h8000_0000, 32'd0, 1'b1, 0, res, lat);
    check("zero_s_lat", 64'(lat), 64'd2);
    check("zero_s_res", res, 64'd0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, res, lat);
    check("div_ovf", res, {32'd0, 32'h8000_0000});
    run(32'hFFFF_FFFF, 32'd1, 1'b0, 0, res, lat);
    check("divu_max", res, {32'd0, 32'hFFFF_FFFF});
    run(32'd1000, 32'd3, 1'b0, 5, res, lat);
    check("hold_res", res, {32'd1, 32'd333});
    // annul at cycle 10, new start at cycle 12
    a = 32'd999; b = 32'd4; sgn = 0; start = 1;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1;
    @(posedge clk); #1;
    annul = 0; start = 0;
    check("annul_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    a = 32'd12345678; b = 32'd1234; start = 1;
    lat = 0;
    while (!ready && lat < 40) begin @(posedge clk); #1; lat++; end
    check("restart_lat", 64'(lat), 64'd33);
    check("restart_res", result, {32'd742, 32'd10004});
    start = 0;
    @(posedge clk); #1;
    // async reset mid-BUSY
    a = 32'd1000; b = 32'd7; start = 1;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1;
    #1;
    check("rst_busy_ready", 64'(ready), 64'd0);
    check("rst_busy_result", result, 64'd0);
    @(posedge clk); #1;
    start = 0; rst = 0;
    @(posedge clk); #1;
    // async reset while a result is held in DONE
    a = 32'd1000; b = 32'd7; start = 1;
    lat = 0;
    while (!ready && lat < 40) begin @(posedge clk); #1; lat++; end
    check("pre_rst_res", result, {32'd6, 32'd142});
    #2 rst = 1;
    #1;
    check("rst_done_ready", 64'(ready), 64'd0);
    check("rst_done_result", result, 64'd0);
    @(posedge clk); #1;
    start = 0; rst = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      sgn = $urandom_range(0, 1);
      start = 1;
      da = ($urandom_range(0, 3) == 0);
      ac = $urandom_range(0, 36);
      i = 0;
      while (!ready && !(da && i == ac) && i < 40) begin
        @(posedge clk); #1;
        i++;
        if (i == 1) begin a = $urandom; b = $urandom; sgn = $urandom_range(0, 1); end
      end
      if (!da) check("rand_ready", 64'(ready), 64'd1);
      if (da) begin
        annul = 1;
        @(posedge clk); #1;
        annul = 0;
      end else begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      start = 0;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
